// File: rtl/grad_update_sched.sv
// DAC gradient update scheduler: shadow/pending channel sets,
// init and update bursts of four words to the OCRA1 serial core.
module grad_update_sched #(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_i,
  input  logic [1:0]            wr_ch_i,
  input  logic [17:0]           wr_val_i,
  input  logic                  commit_i,
  input  logic                  init_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic                  clr_i,
  input  logic                  busy_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  output logic                  done_o,
  output logic                  pending_o,
  output logic                  overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            cnt_q, cnt_d;
  logic                  gap_q, gap_d;
  logic                  valid_d, done_d;
  logic [31:0]           data_d;
  logic [3:0][17:0]      shadow_q;
  logic [3:0][17:0]      pend_q;
  logic [3:0][17:0]      snap_q;
  logic                  kind_q;
  logic                  init_q;
  logic [INTERVAL_W-1:0] timer_q;
  logic [INTERVAL_W-1:0] load;
  logic                  go;
  logic                  start_upd;
  logic                  ovr_set;

  function automatic logic [31:0] fmt(
    input logic [1:0]  ch,
    input logic        init,
    input logic [17:0] val
  );
    logic [23:0] pl;
    pl = init ? 24'h200002 : {4'h1, val, 2'b00};
    return {5'd0, ch, (ch == 2'd3), pl};
  endfunction

  assign go = (state_q == IDLE) && (init_q || pending_o)
           && (timer_q == '0) && !busy_i;
  assign start_upd = go && !init_q;

  // Loaded one short so the next burst can start exactly
  // interval_i clocks after this one (IDLE needs one cycle to see 0).
  assign load = (interval_i == '0) ? '0
              : interval_i - INTERVAL_W'(1);

  // The set being sent at this very edge is not lost, so no overrun.
  assign ovr_set = commit_i && pending_o
                && (state_q != SEND) && !start_upd;

  // Burst sequencing and next output word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    data_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SEND;
          cnt_d   = 2'd1;
          valid_d = 1'b1;
          data_d  = fmt(2'd0, init_q, pend_q[0]);
        end
      end
      SEND: begin
        if (cnt_q != 2'd0) begin
          valid_d = 1'b1;
          data_d  = fmt(cnt_q, kind_q, snap_q[cnt_q]);
          cnt_d   = cnt_q + 2'd1;
        end else begin
          state_d = GAP;
          done_d  = 1'b1;
          gap_d   = 1'b0;
        end
      end
      GAP: begin
        gap_d = 1'b1;
        if (gap_q) begin
          state_d = IDLE;
          gap_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      valid_o <= valid_d;
      done_o  <= done_d;
      data_o  <= data_d;
    end
  end

  // Shadow writes, commit copy and in-flight snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      pend_q   <= '0;
      snap_q   <= '0;
      kind_q   <= 1'b0;
    end else begin
      if (wr_i)
        shadow_q[wr_ch_i] <= wr_val_i;
      if (commit_i) begin
        for (int i = 0; i < 4; i++)
          pend_q[i] <= (wr_i && wr_ch_i == 2'(i))
                     ? wr_val_i : shadow_q[i];
      end
      if (go) begin
        snap_q <= pend_q;
        kind_q <= init_q;
      end
    end
  end

  // Request flags: init, pending set, sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      pending_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      init_q <= init_i || (init_q && !(go && init_q));
      if (commit_i)
        pending_o <= 1'b1;
      else if (start_upd)
        pending_o <= 1'b0;
      if (ovr_set)
        overrun_o <= 1'b1;
      else if (clr_i)
        overrun_o <= 1'b0;
    end
  end

  // Minimum burst-to-burst interval timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer_q <= '0;
    else if (go)
      timer_q <= load;
    else if (timer_q != '0)
      timer_q <= timer_q - INTERVAL_W'(1);
  end

endmodule

// File: tb/tb_grad_update_sched.sv
// Scoreboard bench for grad_update_sched: directed bursts,
// interval, busy hold-off, overrun and mid-burst reset.
module tb_grad_update_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_i = 1'b0;
  logic [1:0]  wr_ch_i = '0;
  logic [17:0] wr_val_i = '0;
  logic        commit_i = 1'b0;
  logic        init_i = 1'b0;
  logic [15:0] interval_i = '0;
  logic        clr_i = 1'b0;
  logic        busy_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        done_o;
  logic        pending_o;
  logic        overrun_o;

  grad_update_sched #(.INTERVAL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_i(wr_i), .wr_ch_i(wr_ch_i), .wr_val_i(wr_val_i),
    .commit_i(commit_i), .init_i(init_i),
    .interval_i(interval_i), .clr_i(clr_i), .busy_i(busy_i),
    .data_o(data_o), .valid_o(valid_o), .done_o(done_o),
    .pending_o(pending_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c_cyc;
  int b_cyc;
  int n0;
  logic [31:0] exp_q[$];
  int start_q[$];
  logic vprev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid word.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (!vprev) start_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h want none", data_o);
      end else begin
        chk("word", data_o, exp_q.pop_front());
      end
    end
    vprev = rst_n && valid_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] a, b, c, d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [17:0] v);
    wr_i = 1'b1;
    wr_ch_i = ch;
    wr_val_i = v;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    c_cyc = cyc;
    tick();
    commit_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_start(input string nm, input int n,
                            input int budget);
    for (int i = 0; i < budget && start_q.size() < n; i++)
      @(negedge clk);
    chk(nm, 32'(start_q.size() >= n), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_data", data_o, 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // init burst
    push4(32'h00200002, 32'h02200002, 32'h04200002, 32'h07200002);
    init_i = 1'b1;
    tick();
    init_i = 1'b0;
    wait_done("init_done", 20);
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'd0);
    repeat (4) tick();

    // shadow writes stay hidden until commit
    n0 = start_q.size();
    wr(2'd0, 18'd1);
    wr(2'd1, 18'd2);
    wr(2'd2, 18'd3);
    wr(2'd3, 18'd4);
    repeat (5) tick();
    chk("no_commit_quiet", start_q.size(), n0);
    chk("no_commit_pend", 32'(pending_o), 32'd0);

    // update burst, latency 2 after commit
    push4(32'h00100004, 32'h02100008, 32'h0410000C, 32'h07100010);
    commit();
    wait_start("upd_start", n0 + 1, 20);
    chk("upd_latency", start_q[n0] - c_cyc, 32'd2);
    wait_done("upd_done", 20);
    chk("pend_cleared", 32'(pending_o), 32'd0);
    repeat (4) tick();

    // interval 100, two commits 10 cycles apart
    interval_i = 16'd100;
    n0 = start_q.size();
    push4(32'h00100004, 32'h02100008, 32'h0410000C, 32'h07100010);
    commit();
    repeat (9) tick();
    push4(32'h00100004, 32'h02100008, 32'h0410000C, 32'h07100010);
    commit();
    chk("ivl_no_overrun", 32'(overrun_o), 32'd0);
    wait_start("ivl_second", n0 + 2, 150);
    chk("ivl_gap", start_q[n0 + 1] - start_q[n0], 32'd100);
    wait_done("ivl_done", 20);
    interval_i = 16'd0;
    repeat (110) tick();

    // busy hold-off
    busy_i = 1'b1;
    n0 = start_q.size();
    push4(32'h00100004, 32'h02100008, 32'h0410000C, 32'h07100010);
    commit();
    repeat (50) tick();
    chk("busy_quiet", start_q.size(), n0);
    chk("busy_pend", 32'(pending_o), 32'd1);
    busy_i = 1'b0;
    b_cyc = cyc;
    wait_start("busy_start", n0 + 1, 20);
    chk("busy_release", start_q[n0] - b_cyc, 32'd1);
    wait_done("busy_done", 20);
    repeat (4) tick();

    // overrun: only newest set is sent
    busy_i = 1'b1;
    n0 = start_q.size();
    commit();
    wr(2'd0, 18'd13);
    wr(2'd1, 18'd14);
    wr(2'd2, 18'd15);
    wr(2'd3, 18'd16);
    chk("ovr_clear_before", 32'(overrun_o), 32'd0);
    commit();
    chk("ovr_set", 32'(overrun_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("ovr_clr", 32'(overrun_o), 32'd0);
    clr_i = 1'b1;
    commit();
    clr_i = 1'b0;
    chk("ovr_set_wins", 32'(overrun_o), 32'd1);
    push4(32'h00100034, 32'h02100038, 32'h0410003C, 32'h07100040);
    busy_i = 1'b0;
    wait_done("ovr_done", 20);
    chk("ovr_one_burst", start_q.size(), n0 + 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("ovr_clr2", 32'(overrun_o), 32'd0);
    repeat (4) tick();

    // reset on the second word
    n0 = start_q.size();
    push4(32'h00100034, 32'h02100038, 32'h0410003C, 32'h07100040);
    commit();
    wait_start("rst_burst", n0 + 1, 20);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_data", data_o, 32'd0);
    chk("mid_rst_pend", 32'(pending_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_ovr", 32'(overrun_o), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_resume", start_q.size(), n0 + 1);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
